// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S stereo serializer with clk-derived MCLK/SCK/LRCK
//
// Purpose:
//   Captures a left/right sample pair once per 1024-clk frame and shifts it out
//   MSB-first in standard I2S format (one SCK delay after each LRCK edge).
//   All interface clocks are bits of one free-running 10-bit divider.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   asynchronous reset, active high
//   audio_left   in   SAMPLE_W left sample, two's complement
//   audio_right  in   SAMPLE_W right sample, two's complement
//   mute         in   forces both captured samples to 0 at capture time
//   audio_mclk   out  clk/4
//   audio_lrck   out  clk/1024, 0 = left half, 1 = right half
//   audio_sck    out  clk/16, 64 per frame
//   audio_sdin   out  serial data, changes on SCK falling edge
//   sample_tick  out  one-clk pulse while cnt == 0 (request next pair)
module i2s_audio_tx #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                mute,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin,
    output logic                sample_tick
);

    logic [9:0]          cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                sdin_q, sdin_d;
    logic                tick_q, tick_d;

    logic                wrap;
    logic                bit_edge;
    logic [4:0]          next_slot;
    logic [SAMPLE_W-1:0] next_word;

    always_comb begin
        cnt_d     = cnt_q + 10'd1;
        wrap      = (cnt_q == 10'd1023);
        // Last clk of an SCK period: the next edge is the SCK falling edge.
        bit_edge  = (cnt_q[3:0] == 4'hF);
        next_slot = cnt_d[8:4];
        next_word = cnt_d[9] ? hold_r_q : hold_l_q;

        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (wrap) begin
            hold_l_d = mute ? '0 : audio_left;
            hold_r_d = mute ? '0 : audio_right;
        end

        tick_d = wrap;

        shift_d = shift_q;
        sdin_d  = sdin_q;
        if (bit_edge) begin
            if (next_slot == 5'd0) begin
                // I2S one-bit delay slot; the holding register may be
                // reloading on this very edge, so it is not consulted here.
                sdin_d  = 1'b0;
                shift_d = '0;
            end else if (next_slot == 5'd1) begin
                sdin_d  = next_word[SAMPLE_W-1];
                shift_d = next_word << 1;
            end else begin
                // Zero fill means slots past the sample width carry 0.
                sdin_d  = shift_q[SAMPLE_W-1];
                shift_d = shift_q << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            shift_q  <= '0;
            sdin_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            shift_q  <= shift_d;
            sdin_q   <= sdin_d;
            tick_q   <= tick_d;
        end
    end

    // Interface clocks come straight from register bits, so they are glitch-free.
    assign audio_mclk  = cnt_q[1];
    assign audio_sck   = cnt_q[3];
    assign audio_lrck  = cnt_q[9];
    assign audio_sdin  = sdin_q;
    assign sample_tick = tick_q;

endmodule
